// File: rtl/bist_pkg.sv
// Shared definitions for the BIST controller: FSM encoding, pattern LFSR
// width/taps and the LFSR step function.
package bist_pkg;

    localparam int unsigned LFSR_W = 4;

    // Feedback taps on q[3] and q[2].
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_CMP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_tpg.sv
// 4-bit maximal-length pattern LFSR; reset and load both restore the seed.
module bist_tpg
    import bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 4'b0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst || load) begin
            q <= SEED;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// BIST sequencer: seeds the MISR, drives LFSR test requests into the arbiter,
// flushes in-flight grants and compares the final signature against GOLDEN.
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int                NBIT     = 6,
    parameter int                NPAT     = 64,
    parameter int                CUT_LAT  = 1,
    parameter logic [NBIT-1:0]   GOLDEN   = '0,
    parameter logic [LFSR_W-1:0] TPG_SEED = 4'b0001
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [NBIT-1:0] signature,
    output logic            misr_rst,
    output logic            test_mode,
    output logic [3:0]      req_pat,
    output logic            busy,
    output logic            done,
    output logic            pass
);

    localparam int CNT_W = $clog2(NPAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPAT - 1);
    localparam logic [2:0] FL_LAST = (CUT_LAT > 0) ? 3'(CUT_LAT - 1) : 3'd0;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    pat_cnt;
    logic [2:0]          fl_cnt;
    logic [LFSR_W-1:0]   tpg_q;
    logic                tpg_load;
    logic                tpg_en;
    logic                pass_q;
    logic                in_run;

    bist_tpg #(
        .SEED (TPG_SEED)
    ) u_tpg (
        .clk  (clk),
        .rst  (rst),
        .load (tpg_load),
        .en   (tpg_en),
        .q    (tpg_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign in_run = (state == ST_SEED) || (state == ST_RUN) ||
                    (state == ST_FLUSH) || (state == ST_CMP);

    always_comb begin
        state_nxt = state;
        misr_rst  = 1'b0;
        test_mode = 1'b0;
        req_pat   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        tpg_load  = 1'b0;
        tpg_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                misr_rst = 1'b1;
                if (start) state_nxt = ST_SEED;
            end
            ST_SEED: begin
                misr_rst  = 1'b1;
                test_mode = 1'b1;
                busy      = 1'b1;
                tpg_load  = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                req_pat   = tpg_q;
                tpg_en    = 1'b1;
                if (pat_cnt == CNT_LAST) begin
                    state_nxt = (CUT_LAT == 0) ? ST_CMP : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                if (fl_cnt == FL_LAST) state_nxt = ST_CMP;
            end
            ST_CMP: begin
                test_mode = 1'b1;
                busy      = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides every transition out of the active states.
        if (abort && in_run) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_cnt <= '0;
            fl_cnt  <= '0;
            pass_q  <= 1'b0;
        end else begin
            if (state == ST_SEED) begin
                pat_cnt <= '0;
            end else if (state == ST_RUN) begin
                pat_cnt <= pat_cnt + 1'b1;
            end

            if (state == ST_FLUSH) begin
                fl_cnt <= fl_cnt + 3'd1;
            end else begin
                fl_cnt <= '0;
            end

            if ((abort && in_run) || state == ST_SEED || (state == ST_DONE && !start)) begin
                pass_q <= 1'b0;
            end else if (state == ST_CMP) begin
                pass_q <= (signature == GOLDEN);
            end
        end
    end

    assign pass = pass_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Directed bench for bist_ctrl: three configurations share the inputs, each
// scenario task checks one instance against hand-computed output vectors.
module tb_bist_ctrl;

    // Output vector layout: {misr_rst, test_mode, req_pat[3:0], busy, done, pass}
    localparam logic [8:0] EX_IDLE  = 9'b1_0_0000_0_0_0;
    localparam logic [8:0] EX_SEED  = 9'b1_1_0000_1_0_0;
    localparam logic [8:0] EX_FLUSH = 9'b0_1_0000_1_0_0;
    localparam logic [8:0] EX_DONE0 = 9'b0_0_0000_0_1_0;
    localparam logic [8:0] EX_DONE1 = 9'b0_0_0000_0_1_1;
    localparam logic [5:0] GOLD_A   = 6'h2D;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [5:0] sig;

    logic       a_misr_rst, a_test_mode, a_busy, a_done, a_pass;
    logic [3:0] a_req_pat;
    logic       b_misr_rst, b_test_mode, b_busy, b_done, b_pass;
    logic [3:0] b_req_pat;
    logic       c_misr_rst, c_test_mode, c_busy, c_done, c_pass;
    logic [3:0] c_req_pat;
    logic [8:0] a_out, b_out, c_out;

    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    int total = 0;
    int bad   = 0;

    assign a_out = {a_misr_rst, a_test_mode, a_req_pat, a_busy, a_done, a_pass};
    assign b_out = {b_misr_rst, b_test_mode, b_req_pat, b_busy, b_done, b_pass};
    assign c_out = {c_misr_rst, c_test_mode, c_req_pat, c_busy, c_done, c_pass};

    bist_ctrl #(.NBIT(6), .NPAT(4), .CUT_LAT(1), .GOLDEN(GOLD_A), .TPG_SEED(4'b0001)) u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .signature(sig),
        .misr_rst(a_misr_rst), .test_mode(a_test_mode), .req_pat(a_req_pat),
        .busy(a_busy), .done(a_done), .pass(a_pass)
    );

    bist_ctrl #(.NBIT(6), .NPAT(1), .CUT_LAT(0), .GOLDEN(6'h00), .TPG_SEED(4'b0001)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .signature(sig),
        .misr_rst(b_misr_rst), .test_mode(b_test_mode), .req_pat(b_req_pat),
        .busy(b_busy), .done(b_done), .pass(b_pass)
    );

    bist_ctrl #(.NBIT(6), .NPAT(20), .CUT_LAT(2), .GOLDEN(6'h00), .TPG_SEED(4'b0001)) u_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .signature(sig),
        .misr_rst(c_misr_rst), .test_mode(c_test_mode), .req_pat(c_req_pat),
        .busy(c_busy), .done(c_done), .pass(c_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        sig   = '0;
        tick;
        tick;
        total++; if (a_out !== EX_IDLE) begin bad++; $display("FAIL reset_a got=%b exp=%b", a_out, EX_IDLE); end
        total++; if (b_out !== EX_IDLE) begin bad++; $display("FAIL reset_b got=%b exp=%b", b_out, EX_IDLE); end
        total++; if (c_out !== EX_IDLE) begin bad++; $display("FAIL reset_c got=%b exp=%b", c_out, EX_IDLE); end
        start = 1'b0;
        rst   = 1'b1;
    endtask

    task automatic test_nominal;
        logic [8:0] exp;
        do_reset;
        sig   = GOLD_A;
        start = 1'b1;
        tick;
        total++; if (a_out !== EX_SEED) begin bad++; $display("FAIL nom_seed got=%b exp=%b", a_out, EX_SEED); end
        for (int i = 0; i < 4; i++) begin
            tick;
            exp = {2'b01, seq[i], 3'b100};
            total++; if (a_out !== exp) begin bad++; $display("FAIL nom_run%0d got=%b exp=%b", i, a_out, exp); end
        end
        tick;
        total++; if (a_out !== EX_FLUSH) begin bad++; $display("FAIL nom_flush got=%b exp=%b", a_out, EX_FLUSH); end
        tick;
        total++; if (a_out !== EX_FLUSH) begin bad++; $display("FAIL nom_cmp got=%b exp=%b", a_out, EX_FLUSH); end
        tick;
        total++; if (a_out !== EX_DONE1) begin bad++; $display("FAIL nom_done got=%b exp=%b", a_out, EX_DONE1); end
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (a_out !== EX_DONE1) begin bad++; $display("FAIL nom_hold%0d got=%b exp=%b", i, a_out, EX_DONE1); end
        end
        start = 1'b0;
        tick;
        total++; if (a_out !== EX_IDLE) begin bad++; $display("FAIL nom_idle got=%b exp=%b", a_out, EX_IDLE); end
    endtask

    task automatic test_fail;
        do_reset;
        sig   = GOLD_A ^ 6'h01;
        start = 1'b1;
        repeat (8) tick;
        total++; if (a_out !== EX_DONE0) begin bad++; $display("FAIL fail_done got=%b exp=%b", a_out, EX_DONE0); end
        sig = GOLD_A;
        tick;
        total++; if (a_out !== EX_DONE0) begin bad++; $display("FAIL fail_hold got=%b exp=%b", a_out, EX_DONE0); end
        start = 1'b0;
        tick;
    endtask

    task automatic test_abort;
        logic [8:0] exp;
        do_reset;
        sig   = GOLD_A;
        start = 1'b1;
        tick;
        tick;
        tick;
        exp = {2'b01, 4'h2, 3'b100};
        total++; if (a_out !== exp) begin bad++; $display("FAIL abort_run2 got=%b exp=%b", a_out, exp); end
        abort = 1'b1;
        tick;
        total++; if (a_out !== EX_IDLE) begin bad++; $display("FAIL abort_idle got=%b exp=%b", a_out, EX_IDLE); end
        abort = 1'b0;
        tick;
        total++; if (a_out !== EX_SEED) begin bad++; $display("FAIL abort_restart got=%b exp=%b", a_out, EX_SEED); end
        repeat (6) tick;
        total++; if (a_out !== EX_FLUSH) begin bad++; $display("FAIL abort_at_cmp got=%b exp=%b", a_out, EX_FLUSH); end
        abort = 1'b1;
        tick;
        total++; if (a_out !== EX_IDLE) begin bad++; $display("FAIL abort_cmp got=%b exp=%b", a_out, EX_IDLE); end
        tick;
        total++; if (a_out !== EX_SEED) begin bad++; $display("FAIL abort_idle_ignored got=%b exp=%b", a_out, EX_SEED); end
        abort = 1'b0;
        repeat (7) tick;
        total++; if (a_out !== EX_DONE1) begin bad++; $display("FAIL abort_rerun_done got=%b exp=%b", a_out, EX_DONE1); end
        abort = 1'b1;
        tick;
        total++; if (a_out !== EX_DONE1) begin bad++; $display("FAIL abort_done_ignored got=%b exp=%b", a_out, EX_DONE1); end
        abort = 1'b0;
        start = 1'b0;
        tick;
    endtask

    task automatic test_reset_midrun;
        logic [8:0] exp;
        do_reset;
        sig   = GOLD_A;
        start = 1'b1;
        repeat (6) tick;
        total++; if (a_out !== EX_FLUSH) begin bad++; $display("FAIL rst_at_flush got=%b exp=%b", a_out, EX_FLUSH); end
        rst = 1'b0;
        tick;
        total++; if (a_out !== EX_IDLE) begin bad++; $display("FAIL rst_flush_idle got=%b exp=%b", a_out, EX_IDLE); end
        rst = 1'b1;
        tick;
        total++; if (a_out !== EX_SEED) begin bad++; $display("FAIL rst_restart_seed got=%b exp=%b", a_out, EX_SEED); end
        tick;
        exp = {2'b01, 4'h1, 3'b100};
        total++; if (a_out !== exp) begin bad++; $display("FAIL rst_restart_run got=%b exp=%b", a_out, exp); end
        start = 1'b0;
    endtask

    task automatic test_boundary;
        logic [8:0] exp;
        do_reset;
        sig   = '0;
        start = 1'b1;
        tick;
        total++; if (b_out !== EX_SEED) begin bad++; $display("FAIL bnd_seed got=%b exp=%b", b_out, EX_SEED); end
        tick;
        exp = {2'b01, 4'h1, 3'b100};
        total++; if (b_out !== exp) begin bad++; $display("FAIL bnd_run got=%b exp=%b", b_out, exp); end
        start = 1'b0;
        tick;
        total++; if (b_out !== EX_FLUSH) begin bad++; $display("FAIL bnd_cmp got=%b exp=%b", b_out, EX_FLUSH); end
        start = 1'b1;
        tick;
        total++; if (b_out !== EX_DONE1) begin bad++; $display("FAIL bnd_done got=%b exp=%b", b_out, EX_DONE1); end
        tick;
        total++; if (b_out !== EX_DONE1) begin bad++; $display("FAIL bnd_hold got=%b exp=%b", b_out, EX_DONE1); end
        start = 1'b0;
        tick;
        total++; if (b_out !== EX_IDLE) begin bad++; $display("FAIL bnd_idle got=%b exp=%b", b_out, EX_IDLE); end
    endtask

    task automatic test_long;
        logic [8:0] exp;
        do_reset;
        sig   = '0;
        start = 1'b1;
        tick;
        total++; if (c_out !== EX_SEED) begin bad++; $display("FAIL long_seed got=%b exp=%b", c_out, EX_SEED); end
        for (int i = 0; i < 20; i++) begin
            tick;
            exp = {2'b01, seq[i % 15], 3'b100};
            total++; if (c_out !== exp) begin bad++; $display("FAIL long_run%0d got=%b exp=%b", i, c_out, exp); end
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            total++; if (c_out !== EX_FLUSH) begin bad++; $display("FAIL long_flush%0d got=%b exp=%b", i, c_out, EX_FLUSH); end
        end
        tick;
        total++; if (c_out !== EX_FLUSH) begin bad++; $display("FAIL long_cmp got=%b exp=%b", c_out, EX_FLUSH); end
        tick;
        total++; if (c_out !== EX_DONE1) begin bad++; $display("FAIL long_done got=%b exp=%b", c_out, EX_DONE1); end
        start = 1'b0;
        tick;
        total++; if (c_out !== EX_IDLE) begin bad++; $display("FAIL long_idle got=%b exp=%b", c_out, EX_IDLE); end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        sig   = '0;
        test_reset;
        test_nominal;
        test_fail;
        test_abort;
        test_reset_midrun;
        test_boundary;
        test_long;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
